// File: rtl/st2_decode.sv
// rtl/st2_decode.sv - MIPS-subset decode stage: latches fetch output, decodes, resolves jumps/branches
module st2_decode (
    input  logic         clk,
    input  logic         resetn,
    input  logic         IF_over,
    input  logic [63:0]  IF_ID_bus,
    input  logic         ID_valid,
    output logic [4:0]   rs_addr,
    output logic [4:0]   rt_addr,
    input  logic [31:0]  rs_value,
    input  logic [31:0]  rt_value,
    output logic [32:0]  jbr_bus,
    output logic         ID_over,
    output logic [139:0] ID_EXE_bus,
    output logic         ID_illegal,
    output logic [31:0]  ID_pc,
    output logic [31:0]  ID_inst
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLT = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    logic [31:0] pc_r;
    logic [31:0] inst_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_r    <= 32'd0;
            inst_r  <= 32'd0;
            ID_over <= 1'b0;
        end else begin
            if (IF_over) begin
                pc_r   <= IF_ID_bus[63:32];
                inst_r <= IF_ID_bus[31:0];
            end
            ID_over <= ID_valid;
        end
    end

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [31:0] simm;
    logic [31:0] pc4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign opcode    = inst_r[31:26];
    assign rs_addr   = inst_r[25:21];
    assign rt_addr   = inst_r[20:16];
    assign rd        = inst_r[15:11];
    assign sa        = inst_r[10:6];
    assign funct     = inst_r[5:0];
    assign imm       = inst_r[15:0];
    assign simm      = {{16{imm[15]}}, imm};
    assign pc4       = pc_r + 32'd4;
    assign br_target = pc4 + {simm[29:0], 2'b00};
    assign j_target  = {pc4[31:28], inst_r[25:0], 2'b00};

    logic [3:0]  alu_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        mem_rd;
    logic        mem_wr;
    logic        wen_raw;
    logic [4:0]  rf_wdest;
    logic        taken_raw;
    logic [31:0] jbr_target;
    logic        illegal;

    always_comb begin
        alu_op     = ALU_ADD;
        op1        = rs_value;
        op2        = rt_value;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        wen_raw    = 1'b0;
        rf_wdest   = 5'd0;
        taken_raw  = 1'b0;
        jbr_target = br_target;
        illegal    = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                rf_wdest = rd;
                wen_raw  = 1'b1;
                case (funct)
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_SLL: begin
                        alu_op = ALU_SLL;
                        op1    = rt_value;
                        op2    = {27'd0, sa};
                    end
                    default: begin
                        illegal = 1'b1;
                        wen_raw = 1'b0;
                    end
                endcase
            end
            OP_ADDIU: begin
                op2      = simm;
                rf_wdest = rt_addr;
                wen_raw  = 1'b1;
            end
            OP_LUI: begin
                alu_op   = ALU_LUI;
                op2      = {imm, 16'd0};
                rf_wdest = rt_addr;
                wen_raw  = 1'b1;
            end
            OP_LW: begin
                op2      = simm;
                rf_wdest = rt_addr;
                wen_raw  = 1'b1;
                mem_rd   = 1'b1;
            end
            OP_SW: begin
                op2    = simm;
                mem_wr = 1'b1;
            end
            OP_BEQ: taken_raw = (rs_value == rt_value);
            OP_BNE: taken_raw = (rs_value != rt_value);
            OP_J: begin
                jbr_target = j_target;
                taken_raw  = 1'b1;
            end
            OP_JAL: begin
                // No delay slot, so the link value is pc+4.
                jbr_target = j_target;
                taken_raw  = 1'b1;
                op1        = pc4;
                op2        = 32'd0;
                rf_wdest   = 5'd31;
                wen_raw    = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    logic rf_wen;
    assign rf_wen = wen_raw & (rf_wdest != 5'd0);

    assign jbr_bus    = {taken_raw & ID_over, jbr_target};
    assign ID_illegal = illegal & ID_over;
    assign ID_EXE_bus = {alu_op, op1, op2, rt_value, mem_rd, mem_wr, rf_wen, rf_wdest, pc_r};
    assign ID_pc      = pc_r;
    assign ID_inst    = inst_r;

endmodule

// File: tb/tb_st2_decode.sv
// tb/tb_st2_decode.sv - randomized and directed bench for st2_decode against a kind-level model
module tb_st2_decode;

    logic         clk = 1'b0;
    logic         resetn;
    logic         IF_over;
    logic [63:0]  IF_ID_bus;
    logic         ID_valid;
    logic [4:0]   rs_addr;
    logic [4:0]   rt_addr;
    logic [31:0]  rs_value;
    logic [31:0]  rt_value;
    logic [32:0]  jbr_bus;
    logic         ID_over;
    logic [139:0] ID_EXE_bus;
    logic         ID_illegal;
    logic [31:0]  ID_pc;
    logic [31:0]  ID_inst;

    always #5 clk = ~clk;

    st2_decode dut (
        .clk(clk), .resetn(resetn), .IF_over(IF_over), .IF_ID_bus(IF_ID_bus),
        .ID_valid(ID_valid), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_value(rs_value), .rt_value(rt_value), .jbr_bus(jbr_bus),
        .ID_over(ID_over), .ID_EXE_bus(ID_EXE_bus), .ID_illegal(ID_illegal),
        .ID_pc(ID_pc), .ID_inst(ID_inst)
    );

    logic [31:0] regs [32];
    assign rs_value = regs[rs_addr];
    assign rt_value = regs[rt_addr];

    wire [3:0]  f_alu   = ID_EXE_bus[139:136];
    wire [31:0] f_op1   = ID_EXE_bus[135:104];
    wire [31:0] f_op2   = ID_EXE_bus[103:72];
    wire [31:0] f_sdata = ID_EXE_bus[71:40];
    wire        f_mrd   = ID_EXE_bus[39];
    wire        f_mwr   = ID_EXE_bus[38];
    wire        f_wen   = ID_EXE_bus[37];
    wire [4:0]  f_dest  = ID_EXE_bus[36:32];
    wire [31:0] f_pc    = ID_EXE_bus[31:0];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef enum {K_ADDU, K_SUBU, K_SLT, K_AND, K_OR, K_XOR, K_SLL, K_ADDIU, K_LUI,
                  K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_t;

    logic [3:0]  e_alu;
    logic [31:0] e_op1, e_op2, e_target;
    logic        e_mrd, e_mwr, e_wen, e_taken, e_ill;
    logic [4:0]  e_dest;
    bit          care_ops, care_dest, care_target;

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0F, 6'h23, 6'h2B};
    endfunction

    function automatic bit legal_fn(input logic [5:0] fn);
        return fn inside {6'h00, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A};
    endfunction

    task automatic make_inst(input kind_t k, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                             input logic [25:0] idx, output logic [31:0] inst);
        logic [5:0] op, fn;
        case (k)
            K_ADDU:  inst = {6'h00, rs, rt, rd, sa, 6'h21};
            K_SUBU:  inst = {6'h00, rs, rt, rd, sa, 6'h23};
            K_SLT:   inst = {6'h00, rs, rt, rd, sa, 6'h2A};
            K_AND:   inst = {6'h00, rs, rt, rd, sa, 6'h24};
            K_OR:    inst = {6'h00, rs, rt, rd, sa, 6'h25};
            K_XOR:   inst = {6'h00, rs, rt, rd, sa, 6'h26};
            K_SLL:   inst = {6'h00, rs, rt, rd, sa, 6'h00};
            K_ADDIU: inst = {6'h09, rs, rt, imm};
            K_LUI:   inst = {6'h0F, rs, rt, imm};
            K_LW:    inst = {6'h23, rs, rt, imm};
            K_SW:    inst = {6'h2B, rs, rt, imm};
            K_BEQ:   inst = {6'h04, rs, rt, imm};
            K_BNE:   inst = {6'h05, rs, rt, imm};
            K_J:     inst = {6'h02, idx};
            K_JAL:   inst = {6'h03, idx};
            default: begin
                if ($urandom_range(0, 1) == 1) begin
                    do op = 6'($urandom); while (legal_op(op));
                    inst = {op, idx};
                end else begin
                    do fn = 6'($urandom); while (legal_fn(fn));
                    inst = {6'h00, rs, rt, rd, sa, fn};
                end
            end
        endcase
    endtask

    // Expected behaviour straight from each instruction's architectural meaning.
    task automatic model(input kind_t k, input logic [31:0] inst, input logic [31:0] pc);
        logic [31:0] a, b, sx, nxt;
        logic [4:0]  rs, rt, rd;
        rs = inst[25:21]; rt = inst[20:16]; rd = inst[15:11];
        a = regs[rs]; b = regs[rt];
        sx = 32'($signed(inst[15:0]));
        nxt = pc + 32'd4;
        e_alu = 4'd0; e_op1 = a; e_op2 = b; e_mrd = 0; e_mwr = 0; e_dest = 0;
        e_taken = 0; e_ill = 0; e_target = 0;
        care_ops = 1; care_dest = 1; care_target = 0;
        case (k)
            K_ADDU, K_SUBU, K_SLT, K_AND, K_OR, K_XOR: begin
                e_alu = (k == K_ADDU) ? 4'd0 : (k == K_SUBU) ? 4'd1 : (k == K_SLT) ? 4'd2 :
                        (k == K_AND) ? 4'd3 : (k == K_OR) ? 4'd4 : 4'd5;
                e_dest = rd;
            end
            K_SLL:   begin e_alu = 6; e_op1 = b; e_op2 = 32'(inst[10:6]); e_dest = rd; end
            K_ADDIU: begin e_op2 = sx; e_dest = rt; end
            K_LUI:   begin e_alu = 7; e_op2 = inst[15:0] * 32'd65536; e_dest = rt; end
            K_LW:    begin e_op2 = sx; e_dest = rt; e_mrd = 1; end
            K_SW:    begin e_op2 = sx; e_mwr = 1; care_dest = 0; end
            K_BEQ, K_BNE: begin
                care_ops = 0; care_dest = 0; care_target = 1;
                e_target = nxt + sx * 32'd4;
                e_taken = (k == K_BEQ) ? (a == b) : (a != b);
            end
            K_J, K_JAL: begin
                care_target = 1; e_taken = 1;
                e_target = (nxt & 32'hF000_0000) | (32'(inst[25:0]) * 32'd4);
                if (k == K_JAL) begin e_op1 = nxt; e_op2 = 0; e_dest = 31; end
                else begin care_ops = 0; care_dest = 0; end
            end
            default: begin e_ill = 1; care_ops = 0; care_dest = 0; end
        endcase
        e_wen = (k inside {K_ADDU, K_SUBU, K_SLT, K_AND, K_OR, K_XOR, K_SLL, K_ADDIU,
                           K_LUI, K_LW, K_JAL}) && (e_dest != 0);
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        @(negedge clk);
        IF_ID_bus = {pc, inst}; IF_over = 1; ID_valid = 0;
        @(negedge clk);
        IF_over = 0; ID_valid = 1;
        check("pre_over", ID_over, 1'b0);
        check("pre_taken", jbr_bus[32], 1'b0);
        check("latched_inst", ID_inst, inst);
        @(negedge clk);
        ID_valid = 0;
    endtask

    task automatic compare(input logic [31:0] inst, input logic [31:0] pc);
        check("id_over", ID_over, 1'b1);
        check("illegal", ID_illegal, e_ill);
        check("taken", jbr_bus[32], e_taken);
        check("mem_rd", f_mrd, e_mrd);
        check("mem_wr", f_mwr, e_mwr);
        check("rf_wen", f_wen, e_wen);
        check("store_data", f_sdata, regs[inst[20:16]]);
        check("bus_pc", f_pc, pc);
        check("id_pc", ID_pc, pc);
        check("rs_addr", rs_addr, inst[25:21]);
        check("rt_addr", rt_addr, inst[20:16]);
        if (care_target) check("target", jbr_bus[31:0], e_target);
        if (care_dest) check("rf_wdest", f_dest, e_dest);
        if (care_ops) begin
            check("alu_op", f_alu, e_alu);
            check("op1", f_op1, e_op1);
            check("op2", f_op2, e_op2);
        end
    endtask

    initial begin
        logic [31:0] inst, pc;
        kind_t k;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        resetn = 0; IF_over = 0; ID_valid = 0; IF_ID_bus = 64'd0;
        #1;
        check("rst_over", ID_over, 1'b0);
        check("rst_taken", jbr_bus[32], 1'b0);
        check("rst_illegal", ID_illegal, 1'b0);
        check("rst_pc", ID_pc, 32'd0);
        check("rst_inst", ID_inst, 32'd0);
        check("rst_wen", f_wen, 1'b0);
        repeat (2) @(negedge clk);
        resetn = 1;

        // Directed: BEQ taken, then not taken, then BNE
        regs[1] = 5; regs[2] = 5;
        issue(32'h1022_0003, 32'h10);
        check("beq_bus", jbr_bus, {1'b1, 32'h20});
        regs[2] = 6; #1;
        check("beq_nt", jbr_bus[32], 1'b0);
        issue(32'h1422_0003, 32'h10);
        check("bne_bus", jbr_bus, {1'b1, 32'h20});

        regs[0] = 0;
        issue(32'h2403_FFFF, 32'h10);
        check("addiu_alu", f_alu, 4'd0);
        check("addiu_op1", f_op1, 32'd0);
        check("addiu_op2", f_op2, 32'hFFFF_FFFF);
        check("addiu_wen", f_wen, 1'b1);
        check("addiu_dest", f_dest, 5'd3);
        check("addiu_mem", {f_mrd, f_mwr}, 2'b00);

        issue(32'h0C00_0040, 32'h10);
        check("jal_bus", jbr_bus, {1'b1, 32'h100});
        check("jal_op1", f_op1, 32'h14);
        check("jal_wen", f_wen, 1'b1);
        check("jal_dest", f_dest, 5'd31);

        issue(32'hFC00_0000, 32'h10);
        check("ill_over", ID_over, 1'b1);
        check("ill_flag", ID_illegal, 1'b1);
        check("ill_wen", f_wen, 1'b0);
        check("ill_taken", jbr_bus[32], 1'b0);
        #1 resetn = 0;
        #1;
        check("arst_over", ID_over, 1'b0);
        check("arst_illegal", ID_illegal, 1'b0);
        check("arst_inst", ID_inst, 32'd0);
        @(negedge clk);
        resetn = 1; ID_valid = 1;
        @(negedge clk);
        ID_valid = 0;
        check("post_over", ID_over, 1'b1);
        check("post_illegal", ID_illegal, 1'b0);
        check("post_wen", f_wen, 1'b0);
        check("post_taken", jbr_bus[32], 1'b0);
        @(negedge clk);
        check("over_drop", ID_over, 1'b0);

        for (int n = 0; n < 400; n++) begin
            for (int i = 1; i < 32; i++)
                regs[i] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
            k = kind_t'($urandom_range(0, 15));
            make_inst(k, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                      16'($urandom), 26'($urandom), inst);
            pc = {$urandom} & 32'hFFFF_FFFC;
            model(k, inst, pc);
            issue(inst, pc);
            compare(inst, pc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
